// File: rtl/dkong_wav_player_if.sv
// ROM fetch handshake between the wave player (master) and the sound ROM (slave).
interface dkong_wav_player_if #(
  parameter int unsigned ADDR_W = 19
) ();
  logic [ADDR_W-1:0] rom_ab;
  logic              rom_rd;
  logic              rom_dv;
  logic [7:0]        rom_d;

  modport master (output rom_ab, output rom_rd, input rom_dv, input rom_d);
  modport slave  (input rom_ab, input rom_rd, output rom_dv, output rom_d);
endinterface

// File: rtl/dkong_wav_player.sv
// Multi-trigger wave-sample player with priority preemption and per-trigger step rotation.
// Optional macro DKWAV_QUEUE_EN adds a one-entry pending register for dropped lower-priority edges.
module dkong_wav_player #(
  parameter int unsigned             CLOCK_RATE  = 24000000,
  parameter int unsigned             SAMPLE_RATE = 11025,
  parameter int unsigned             N_TRIG      = 4,
  parameter int unsigned             ADDR_W      = 19,
  parameter int unsigned             OFS_W       = 16,
  parameter logic [ADDR_W-1:0]       ROM_BASE    = ADDR_W'(32'h10000),
  parameter logic [N_TRIG*OFS_W-1:0] TRIG_ADR    = '0,
  parameter logic [N_TRIG*OFS_W-1:0] TRIG_LEN    = '0,
  parameter logic [N_TRIG*2-1:0]     TRIG_STEPS  = '0,
  parameter logic [N_TRIG*OFS_W-1:0] TRIG_STRIDE = '0
) (
  input  logic                      I_CLK,
  input  logic                      I_RST,
  input  logic [N_TRIG-1:0]         I_TRIG,
  input  logic                      I_MUTE,
  dkong_wav_player_if.master        rom,
  output logic [7:0]                O_SAMPLE,
  output logic                      O_ACTIVE,
  output logic [2:0]                O_CH
);

  localparam int unsigned Div  = CLOCK_RATE / SAMPLE_RATE;
  localparam int unsigned CntW = (Div > 1) ? $clog2(Div) : 1;

  typedef enum logic [1:0] {StIdle, StArm, StFetch, StWait} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     tick_cnt_q;
  logic                tick;
  logic [N_TRIG-1:0]   trig_q;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [OFS_W-1:0]    remain_q, remain_d;
  logic [2:0]          ch_q, ch_d;
  logic                active_q, active_d;
  logic [7:0]          sample_q, sample_d;
  logic                got_q, got_d;
  logic [1:0]          step_q [N_TRIG];
  logic [1:0]          step_d [N_TRIG];
`ifdef DKWAV_QUEUE_EN
  logic                pend_v_q, pend_v_d;
  logic [2:0]          pend_ch_q, pend_ch_d;
  logic                drop;
`endif

  logic [N_TRIG-1:0]   en_mask;
  logic [N_TRIG-1:0]   edge_v;
  logic [2:0]          win;
  logic                start;
  logic                end_region;
  logic                cnt_now;
  logic [OFS_W-1:0]    rem_after;
  logic                load;
  logic [2:0]          load_idx;
  logic [OFS_W-1:0]    sel_adr, sel_len, sel_stride;
  logic [1:0]          sel_step;
  logic [OFS_W+1:0]    prod;

  assign tick = (tick_cnt_q == CntW'(Div - 1));

  always_ff @(posedge I_CLK) begin
    if (I_RST || tick) tick_cnt_q <= '0;
    else               tick_cnt_q <= tick_cnt_q + CntW'(1);
  end

  // Edge qualification and priority pick; disabled triggers never reach the FSM.
  always_comb begin
    en_mask = '0;
    win     = '0;
    for (int unsigned i = 0; i < N_TRIG; i++) begin
      en_mask[i] = |TRIG_LEN[i*OFS_W +: OFS_W];
    end
    edge_v = I_TRIG & ~trig_q & en_mask;
    for (int unsigned i = 0; i < N_TRIG; i++) begin
      if (edge_v[i]) win = 3'(i);
    end
    start = (|edge_v) && (!active_q || (win >= ch_q));
`ifdef DKWAV_QUEUE_EN
    drop  = (|edge_v) && active_q && (win < ch_q);
`endif
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    remain_d   = remain_q;
    ch_d       = ch_q;
    active_d   = active_q;
    sample_d   = sample_q;
    got_d      = got_q;
    step_d     = step_q;
`ifdef DKWAV_QUEUE_EN
    pend_v_d   = pend_v_q;
    pend_ch_d  = pend_ch_q;
`endif
    end_region = 1'b0;
    cnt_now    = 1'b0;
    rem_after  = remain_q;
    load       = 1'b0;
    load_idx   = win;
    sel_adr    = '0;
    sel_len    = '0;
    sel_stride = '0;
    sel_step   = '0;
    prod       = '0;

    case (state_q)
      StIdle: ;
      StArm: begin
        if (tick) state_d = StFetch;
      end
      StFetch: begin
        state_d = StWait;
        got_d   = 1'b0;
      end
      StWait: begin
        // A tick without data still consumes the slot so region length stays exact.
        cnt_now = ~got_q & (rom.rom_dv | tick);
        if (~got_q && rom.rom_dv) sample_d = rom.rom_d;
        if (cnt_now) begin
          addr_d   = addr_q + ADDR_W'(1);
          remain_d = remain_q - OFS_W'(1);
          got_d    = 1'b1;
        end
        rem_after = cnt_now ? (remain_q - OFS_W'(1)) : remain_q;
        if (tick) begin
          got_d = 1'b0;
          if (rem_after == '0) end_region = 1'b1;
          else                 state_d    = StFetch;
        end
      end
      default: state_d = StIdle;
    endcase

    if (start) begin
      load     = 1'b1;
      load_idx = win;
`ifdef DKWAV_QUEUE_EN
      pend_v_d = 1'b0;
`endif
    end else if (end_region) begin
      sample_d = 8'h80;
`ifdef DKWAV_QUEUE_EN
      if (pend_v_q) begin
        load     = 1'b1;
        load_idx = pend_ch_q;
        pend_v_d = 1'b0;
      end else begin
        state_d  = StIdle;
        active_d = 1'b0;
      end
`else
      state_d  = StIdle;
      active_d = 1'b0;
`endif
    end

`ifdef DKWAV_QUEUE_EN
    if (drop && (!pend_v_q || (win > pend_ch_q))) begin
      pend_v_d  = 1'b1;
      pend_ch_d = win;
    end
`endif

    if (load) begin
      for (int unsigned i = 0; i < N_TRIG; i++) begin
        if (load_idx == 3'(i)) begin
          sel_adr    = TRIG_ADR[i*OFS_W +: OFS_W];
          sel_len    = TRIG_LEN[i*OFS_W +: OFS_W];
          sel_stride = TRIG_STRIDE[i*OFS_W +: OFS_W];
          sel_step   = step_q[i];
          step_d[i]  = (step_q[i] == TRIG_STEPS[i*2 +: 2]) ? 2'd0 : step_q[i] + 2'd1;
        end else begin
          step_d[i]  = 2'd0;
        end
      end
      prod     = (OFS_W+2)'(sel_step) * (OFS_W+2)'(sel_stride);
      addr_d   = ROM_BASE + ADDR_W'(sel_adr) + ADDR_W'(prod);
      remain_d = sel_len;
      ch_d     = load_idx;
      active_d = 1'b1;
      got_d    = 1'b0;
      state_d  = StArm;
    end
  end

  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      state_q   <= StIdle;
      trig_q    <= '0;
      addr_q    <= '0;
      remain_q  <= '0;
      ch_q      <= '0;
      active_q  <= 1'b0;
      sample_q  <= 8'h80;
      got_q     <= 1'b0;
      for (int unsigned i = 0; i < N_TRIG; i++) step_q[i] <= 2'd0;
`ifdef DKWAV_QUEUE_EN
      pend_v_q  <= 1'b0;
      pend_ch_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      trig_q    <= I_TRIG;
      addr_q    <= addr_d;
      remain_q  <= remain_d;
      ch_q      <= ch_d;
      active_q  <= active_d;
      sample_q  <= sample_d;
      got_q     <= got_d;
      step_q    <= step_d;
`ifdef DKWAV_QUEUE_EN
      pend_v_q  <= pend_v_d;
      pend_ch_q <= pend_ch_d;
`endif
    end
  end

  assign rom.rom_ab = addr_q;
  assign rom.rom_rd = (state_q == StFetch);
  assign O_SAMPLE   = I_MUTE ? 8'h80 : sample_q;
  assign O_ACTIVE   = active_q;
  assign O_CH       = ch_q;

endmodule

// File: tb/tb_dkong_wav_player.sv
// Scoreboard bench: stimulus queues expected ROM reads, a monitor pops and checks each read strobe.
module tb_dkong_wav_player;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] trig;
  logic       mute;
  logic [7:0] samp;
  logic       active;
  logic [2:0] ch;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic [18:0] addr;
    logic [2:0]  ch;
    logic [7:0]  samp;
  } exp_t;
  exp_t exp_q[$];

  int rd_cnt   = 0;
  int skip_idx = -1;

  always #5 clk = ~clk;

  dkong_wav_player_if #(.ADDR_W(19)) rom_if ();

  dkong_wav_player #(
    .CLOCK_RATE  (16),
    .SAMPLE_RATE (1),
    .N_TRIG      (3),
    .ADDR_W      (19),
    .OFS_W       (16),
    .ROM_BASE    (19'h10000),
    .TRIG_ADR    ({16'h1000, 16'h3000, 16'h0000}),
    .TRIG_LEN    ({16'd4, 16'd4, 16'd4}),
    .TRIG_STEPS  ({2'd0, 2'd0, 2'd2}),
    .TRIG_STRIDE ({16'h0000, 16'h0000, 16'h0800})
  ) dut (
    .I_CLK    (clk),
    .I_RST    (rst),
    .I_TRIG   (trig),
    .I_MUTE   (mute),
    .rom      (rom_if),
    .O_SAMPLE (samp),
    .O_ACTIVE (active),
    .O_CH     (ch)
  );

  function automatic logic [7:0] romf(input logic [18:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // ROM model: two-cycle read latency, optionally leaves one read unanswered.
  logic        p1_v = 1'b0, p2_v = 1'b0;
  logic [18:0] p1_a = '0, p2_a = '0;
  initial begin
    rom_if.rom_dv = 1'b0;
    rom_if.rom_d  = 8'h00;
    forever begin
      @(negedge clk);
      rom_if.rom_dv = p2_v;
      rom_if.rom_d  = romf(p2_a);
      p2_v = p1_v;
      p2_a = p1_a;
      p1_v = rom_if.rom_rd && (rd_cnt != skip_idx);
      p1_a = rom_if.rom_ab;
      if (rom_if.rom_rd) rd_cnt++;
    end
  end

  // Monitor: every read strobe must match the head of the expectation queue.
  always @(negedge clk) begin
    if (rom_if.rom_rd) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_read", {13'd0, rom_if.rom_ab}, 32'h0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rd_addr", {13'd0, rom_if.rom_ab}, {13'd0, e.addr});
        chk("rd_ch", {29'd0, ch}, {29'd0, e.ch});
        chk("rd_samp", {24'd0, samp}, {24'd0, e.samp});
        chk("rd_active", {31'd0, active}, 32'd1);
      end
    end
  end

  task automatic push_region(input logic [18:0] base, input logic [2:0] c,
                             input logic [7:0] first, input int n, input int skip);
    exp_t e;
    logic [7:0] cur;
    cur = first;
    for (int k = 0; k < n; k++) begin
      e.addr = base + 19'(k);
      e.ch   = c;
      e.samp = cur;
      exp_q.push_back(e);
      if (k != skip) cur = romf(base + 19'(k));
    end
  endtask

  task automatic pulse(input int k);
    trig[k] = 1'b1;
    @(negedge clk);
    trig[k] = 1'b0;
  endtask

  task automatic wait_rd(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rom_if.rom_rd && n < 100);
    if (!rom_if.rom_rd) chk({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (active && n < 600) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_active"}, {31'd0, active}, 32'd0);
    chk({name, "_samp"}, {24'd0, samp}, 32'h80);
    chk({name, "_pending_reads"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst  = 1'b1;
    trig = '0;
    mute = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_active", {31'd0, active}, 32'd0);
    chk("rst_rd", {31'd0, rom_if.rom_rd}, 32'd0);
    chk("rst_samp", {24'd0, samp}, 32'h80);
    chk("rst_ch", {29'd0, ch}, 32'd0);
    chk("rst_ab", {13'd0, rom_if.rom_ab}, 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Basic playback of trigger 1.
    push_region(19'h13000, 3'd1, 8'h80, 4, -1);
    pulse(1);
    wait_idle("basic");

    // One read left unanswered; mute forces midscale without disturbing the held sample.
    rd_cnt   = 0;
    skip_idx = 1;
    push_region(19'h13000, 3'd1, 8'h80, 4, 1);
    pulse(1);
    wait_rd("hold_first");
    repeat (5) @(negedge clk);
    mute = 1'b1;
    #1 chk("mute_samp", {24'd0, samp}, 32'h80);
    mute = 1'b0;
    #1 chk("unmute_samp", {24'd0, samp}, 32'h5A);
    wait_idle("hold");
    skip_idx = -1;

    // Step rotation on trigger 0.
    push_region(19'h10000, 3'd0, 8'h80, 4, -1); pulse(0); wait_idle("step0");
    push_region(19'h10800, 3'd0, 8'h80, 4, -1); pulse(0); wait_idle("step1");
    push_region(19'h11000, 3'd0, 8'h80, 4, -1); pulse(0); wait_idle("step2");
    push_region(19'h10000, 3'd0, 8'h80, 4, -1); pulse(0); wait_idle("step3");

    // Preemption by trigger 2 with a read still in flight; the late data is ignored.
    push_region(19'h10800, 3'd0, 8'h80, 2, -1);
    pulse(0);
    wait_rd("pre_rd0");
    wait_rd("pre_rd1");
    push_region(19'h11000, 3'd2, 8'h5A, 4, -1);
    @(negedge clk);
    pulse(2);
    @(negedge clk);
    chk("preempt_ch", {29'd0, ch}, 32'd2);
    chk("preempt_active", {31'd0, active}, 32'd1);
    wait_idle("preempt");
    push_region(19'h10000, 3'd0, 8'h80, 4, -1);
    pulse(0);
    wait_idle("step_restart");

    // Lower-priority edge during trigger 2.
    push_region(19'h11000, 3'd2, 8'h80, 4, -1);
    pulse(2);
    wait_rd("drop_rd0");
    pulse(1);
`ifdef DKWAV_QUEUE_EN
    push_region(19'h13000, 3'd1, 8'h80, 4, -1);
`endif
    wait_idle("drop");
    repeat (40) @(negedge clk);
    chk("drop_quiet_active", {31'd0, active}, 32'd0);

    // Reset while waiting for ROM data.
    push_region(19'h13000, 3'd1, 8'h80, 1, -1);
    pulse(1);
    wait_rd("rst_rd0");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_active", {31'd0, active}, 32'd0);
    chk("midrst_rd", {31'd0, rom_if.rom_rd}, 32'd0);
    chk("midrst_samp", {24'd0, samp}, 32'h80);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("late_dv_samp", {24'd0, samp}, 32'h80);
    chk("late_dv_active", {31'd0, active}, 32'd0);
    repeat (40) @(negedge clk);
    chk("final_queue", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
